// File: rtl/branch_pkg.sv
// branch_pkg: shared branch_type bit indices, FSM encoding and reset PC for the redirect controller.
package branch_pkg;
  localparam int BT_COND_TAKEN = 0;
  localparam int BT_JAL = 1;
  localparam int BT_JALR = 2;
  localparam int BT_COND_NT = 3;
  localparam logic [3:0] BT_TAKEN_MASK = 4'b0111;
  localparam logic [3:0] BT_NT_ONLY = 4'b1000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REDIRECT = 2'd1,
    DRAIN = 2'd2
  } state_e;
endpackage

// File: rtl/branch_redirect_stats.sv
// branch_redirect_stats: saturating event counters for the redirect controller (BRANCH_REDIRECT_STATS_EN builds only).
module branch_redirect_stats
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc_taken,
  input  logic            inc_not_taken,
  input  logic            inc_wait,
  output logic [XLEN-1:0] stat_taken,
  output logic [XLEN-1:0] stat_not_taken,
  output logic [XLEN-1:0] stat_wait_cycles
);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_taken <= '0;
      stat_not_taken <= '0;
      stat_wait_cycles <= '0;
    end else begin
      stat_taken <= stat_taken + XLEN'(inc_taken & ~&stat_taken);
      stat_not_taken <= stat_not_taken + XLEN'(inc_not_taken & ~&stat_not_taken);
      stat_wait_cycles <= stat_wait_cycles + XLEN'(inc_wait & ~&stat_wait_cycles);
    end
  end
endmodule

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: turns taken EX-stage branches/jumps into a held fetch redirect plus pipeline flushes.
// Optional saturating statistics outputs are enabled by defining BRANCH_REDIRECT_STATS_EN.
module branch_redirect_ctrl
  import branch_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic            stall_in,
  input  logic [3:0]      branch_type,
  input  logic [XLEN-1:0] target_addr,
  input  logic            if_ready,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush_ifid,
  output logic            flush_idex,
  output logic            misalign_err,
  output logic            busy
`ifdef BRANCH_REDIRECT_STATS_EN
  ,
  output logic [XLEN-1:0] stat_taken,
  output logic [XLEN-1:0] stat_not_taken,
  output logic [XLEN-1:0] stat_wait_cycles
`endif
);
  state_e state_q;
  logic redirect_valid_q;
  logic [XLEN-1:0] redirect_pc_q;
  logic misalign_q;
  logic idle;
  logic ex_fire;
  logic take;
  logic aligned_take;
  logic [XLEN-1:0] eff;
  assign idle = state_q == IDLE;
  assign ex_fire = ex_valid & ~stall_in & idle;
  assign take = ex_fire & |(branch_type & BT_TAKEN_MASK);
  // JALR wins priority, and only JALR clears the target's bit 0
  assign eff = branch_type[BT_JALR] ? {target_addr[XLEN-1:1], 1'b0} : target_addr;
  assign aligned_take = take & ~|eff[1:0];
  assign flush_ifid = aligned_take | ~idle;
  assign flush_idex = aligned_take | (state_q == REDIRECT);
  assign busy = ~idle;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc = redirect_pc_q;
  assign misalign_err = misalign_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      redirect_valid_q <= 1'b0;
      redirect_pc_q <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= take & |eff[1:0];
      case (state_q)
        IDLE: if (aligned_take) begin
          state_q <= REDIRECT;
          redirect_valid_q <= 1'b1;
          redirect_pc_q <= eff;
        end
        REDIRECT: if (if_ready) begin
          state_q <= DRAIN;
          redirect_valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`ifdef BRANCH_REDIRECT_STATS_EN
  branch_redirect_stats #(.XLEN(XLEN)) u_stats (
    .clk(clk),
    .rst_n(rst_n),
    .inc_taken(aligned_take),
    .inc_not_taken(ex_fire & (branch_type == BT_NT_ONLY)),
    .inc_wait((state_q == REDIRECT) & ~if_ready),
    .stat_taken(stat_taken),
    .stat_not_taken(stat_not_taken),
    .stat_wait_cycles(stat_wait_cycles)
  );
`endif
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb_branch_redirect_ctrl: directed scoreboard bench; stimulus queues expected handshakes/misalign pulses, a monitor pops them.
module tb_branch_redirect_ctrl;
  localparam int XLEN = 32;
  logic clk = 1'b0;
  logic rst_n;
  logic ex_valid;
  logic stall_in;
  logic [3:0] branch_type;
  logic [XLEN-1:0] target_addr;
  logic if_ready;
  logic redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic flush_ifid;
  logic flush_idex;
  logic misalign_err;
  logic busy;
`ifdef BRANCH_REDIRECT_STATS_EN
  logic [XLEN-1:0] stat_taken;
  logic [XLEN-1:0] stat_not_taken;
  logic [XLEN-1:0] stat_wait_cycles;
`endif
  typedef struct packed {
    logic mis;
    logic [XLEN-1:0] pc;
  } ev_t;
  ev_t sb_q[$];
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  branch_redirect_ctrl #(.XLEN(XLEN), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ex_valid(ex_valid),
    .stall_in(stall_in),
    .branch_type(branch_type),
    .target_addr(target_addr),
    .if_ready(if_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .flush_ifid(flush_ifid),
    .flush_idex(flush_idex),
    .misalign_err(misalign_err),
    .busy(busy)
`ifdef BRANCH_REDIRECT_STATS_EN
    ,
    .stat_taken(stat_taken),
    .stat_not_taken(stat_not_taken),
    .stat_wait_cycles(stat_wait_cycles)
`endif
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic push(input logic mis, input logic [XLEN-1:0] pc);
    ev_t e;
    e.mis = mis;
    e.pc = pc;
    sb_q.push_back(e);
  endtask
  task automatic idle_out(input string name);
    chk({name, "_rv"}, 64'(redirect_valid), 0);
    chk({name, "_fifid"}, 64'(flush_ifid), 0);
    chk({name, "_fidex"}, 64'(flush_idex), 0);
    chk({name, "_busy"}, 64'(busy), 0);
  endtask
  // monitor: one sample per cycle, after the stimulus has driven that cycle's inputs
  always @(negedge clk) begin
    #2;
    if (rst_n && redirect_valid && if_ready) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_handshake: got pc %0h, expected no redirect", redirect_pc);
      end else begin
        ev_t e;
        e = sb_q.pop_front();
        chk("hs_kind", 64'(e.mis), 0);
        chk("hs_pc", 64'(redirect_pc), 64'(e.pc));
      end
    end
    if (rst_n && misalign_err) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_misalign: got 1, expected 0");
      end else begin
        ev_t e;
        e = sb_q.pop_front();
        chk("mis_kind", 64'(e.mis), 1);
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end
  initial begin
    rst_n = 1'b0;
    ex_valid = 1'b0;
    stall_in = 1'b0;
    branch_type = 4'b0;
    target_addr = '0;
    if_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    idle_out("reset");
    chk("reset_pc", 64'(redirect_pc), 0);
    chk("reset_mis", 64'(misalign_err), 0);
`ifdef BRANCH_REDIRECT_STATS_EN
    chk("reset_stat", 64'(stat_taken | stat_not_taken | stat_wait_cycles), 0);
`endif
    rst_n = 1'b1;
    // 1: conditional taken, fetch ready
    @(negedge clk);
    ex_valid = 1'b1; branch_type = 4'b0001; target_addr = 32'h40; if_ready = 1'b1;
    push(1'b0, 32'h40);
    #1;
    chk("t1_n_fifid", 64'(flush_ifid), 1);
    chk("t1_n_fidex", 64'(flush_idex), 1);
    chk("t1_n_busy", 64'(busy), 0);
    @(negedge clk);
    ex_valid = 1'b0; branch_type = 4'b0;
    #1;
    chk("t1_n1_rv", 64'(redirect_valid), 1);
    chk("t1_n1_pc", 64'(redirect_pc), 32'h40);
    chk("t1_n1_flush", 64'({flush_ifid, flush_idex}), 2'b11);
    chk("t1_n1_busy", 64'(busy), 1);
    @(negedge clk);
    #1;
    chk("t1_n2_rv", 64'(redirect_valid), 0);
    chk("t1_n2_flush", 64'({flush_ifid, flush_idex}), 2'b10);
    chk("t1_n2_busy", 64'(busy), 1);
    @(negedge clk);
    #1;
    idle_out("t1_n3");
    // 2: JALR clears bit0, fetch backpressure for 3 cycles
    @(negedge clk);
    ex_valid = 1'b1; branch_type = 4'b0100; target_addr = 32'h101; if_ready = 1'b0;
    push(1'b0, 32'h100);
    #1;
    chk("t2_n_flush", 64'({flush_ifid, flush_idex}), 2'b11);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ex_valid = 1'b0; branch_type = 4'b0;
      #1;
      chk("t2_wait_rv", 64'(redirect_valid), 1);
      chk("t2_wait_pc", 64'(redirect_pc), 32'h100);
      chk("t2_wait_flush", 64'({flush_ifid, flush_idex}), 2'b11);
    end
    @(negedge clk);
    if_ready = 1'b1;
    #1;
    chk("t2_hs_rv", 64'(redirect_valid), 1);
    @(negedge clk);
    if_ready = 1'b0;
    #1;
    chk("t2_drain", 64'({redirect_valid, flush_ifid, flush_idex}), 3'b010);
    @(negedge clk);
    #1;
    idle_out("t2_end");
`ifdef BRANCH_REDIRECT_STATS_EN
    chk("t2_stat_wait", 64'(stat_wait_cycles), 3);
    chk("t2_stat_taken", 64'(stat_taken), 2);
`endif
    // 3: misaligned JAL
    @(negedge clk);
    ex_valid = 1'b1; branch_type = 4'b0010; target_addr = 32'h22;
    push(1'b1, '0);
    #1;
    chk("t3_n_flush", 64'({flush_ifid, flush_idex}), 0);
    @(negedge clk);
    ex_valid = 1'b0; branch_type = 4'b0;
    #1;
    chk("t3_mis", 64'(misalign_err), 1);
    idle_out("t3_n1");
    @(negedge clk);
    #1;
    chk("t3_mis_off", 64'(misalign_err), 0);
    // 4: stall holds off a taken branch for 2 cycles
    @(negedge clk);
    ex_valid = 1'b1; stall_in = 1'b1; branch_type = 4'b0001; target_addr = 32'h80; if_ready = 1'b1;
    #1;
    idle_out("t4_stall0");
    @(negedge clk);
    #1;
    idle_out("t4_stall1");
    @(negedge clk);
    stall_in = 1'b0;
    push(1'b0, 32'h80);
    #1;
    chk("t4_fire_flush", 64'({flush_ifid, flush_idex}), 2'b11);
    @(negedge clk);
    ex_valid = 1'b0; branch_type = 4'b0;
    #1;
    chk("t4_rv", 64'(redirect_valid), 1);
    chk("t4_pc", 64'(redirect_pc), 32'h80);
    @(negedge clk);
    @(negedge clk);
    #1;
    idle_out("t4_end");
    @(negedge clk);
    ex_valid = 1'b1; branch_type = 4'b1000; target_addr = 32'h44;
    #1;
    idle_out("t4_nt");
    @(negedge clk);
    ex_valid = 1'b0; branch_type = 4'b0;
    #1;
    idle_out("t4_nt1");
    chk("t4_nt_pc", 64'(redirect_pc), 32'h80);
    chk("t4_nt_mis", 64'(misalign_err), 0);
`ifdef BRANCH_REDIRECT_STATS_EN
    chk("t4_stat_nt", 64'(stat_not_taken), 1);
    chk("t4_stat_taken", 64'(stat_taken), 3);
`endif
    // 5: all taken bits -> JALR; second branch ignored while busy; reset drops redirect
    @(negedge clk);
    ex_valid = 1'b1; branch_type = 4'b0111; target_addr = 32'h201; if_ready = 1'b0;
    #1;
    chk("t5_flush", 64'({flush_ifid, flush_idex}), 2'b11);
    @(negedge clk);
    branch_type = 4'b0001; target_addr = 32'h300;
    #1;
    chk("t5_rv", 64'(redirect_valid), 1);
    chk("t5_pc", 64'(redirect_pc), 32'h200);
    @(negedge clk);
    #1;
    chk("t5_ignore_pc", 64'(redirect_pc), 32'h200);
    chk("t5_ignore_busy", 64'(busy), 1);
    @(negedge clk);
    rst_n = 1'b0; ex_valid = 1'b0; branch_type = 4'b0;
    #1;
    chk("t5_pre_rst_rv", 64'(redirect_valid), 1);
    @(negedge clk);
    #1;
    idle_out("t5_rst");
    chk("t5_rst_pc", 64'(redirect_pc), 0);
    rst_n = 1'b1;
    @(negedge clk);
    if_ready = 1'b1;
    #1;
    idle_out("t5_after");
    repeat (3) @(negedge clk);
    #3;
    chk("sb_empty", 64'(sb_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
